// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - keyed sprite and obstacle overlay with per-frame collision flags
module sprite_compositor #(
  parameter int          NUM_SPRITES = 2,
  parameter int          SPRITE_DIM  = 24,
  parameter int          COORD_W     = 10,
  parameter int          ADDR_W      = 10,
  parameter int          ROM_LAT     = 1,
  parameter logic [11:0] KEY_RGB     = 12'hF0F,
  parameter int          OBS_HW      = 20,
  parameter int          OBS_HH      = 12
) (
  input  logic                           Clk,
  input  logic                           reset_n,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic                           blank,
  input  logic                           frame_start,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [2*COORD_W-1:0]           obs_xy,
  input  logic                           obs_en,
  output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
  input  logic [NUM_SPRITES*12-1:0]      rom_rgb,
  input  logic [11:0]                    bg_rgb,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue,
  output logic [NUM_SPRITES-1:0]         coll_frame,
  output logic [NUM_SPRITES-1:0]         obs_frame
);

  // Two extra bits give a sign and headroom so offsets near 0 or the right edge never wrap.
  localparam int CW = COORD_W + 2;
  localparam int H  = SPRITE_DIM / 2;
  localparam logic signed [CW-1:0] SPR_LO = CW'(-H);
  localparam logic signed [CW-1:0] SPR_HI = CW'(H - 1);
  localparam logic signed [CW-1:0] OBS_XLO = CW'(-OBS_HW);
  localparam logic signed [CW-1:0] OBS_XHI = CW'(OBS_HW);
  localparam logic signed [CW-1:0] OBS_YLO = CW'(-OBS_HH);
  localparam logic signed [CW-1:0] OBS_YHI = CW'(OBS_HH);

  logic signed [CW-1:0]   px, py, odx, ody;
  logic [NUM_SPRITES-1:0] hit, opaque, coll_set, obs_set;
  logic                   obs_hit;

  logic                   blank_pipe [ROM_LAT];
  logic                   obs_pipe   [ROM_LAT];
  logic [NUM_SPRITES-1:0] hit_pipe   [ROM_LAT];
  logic                   blank_a, obs_a;
  logic [NUM_SPRITES-1:0] hit_a;

  logic [NUM_SPRITES-1:0] coll_acc, obs_acc;
  logic [11:0]            pix;

  assign px = $signed({2'b00, DrawX});
  assign py = $signed({2'b00, DrawY});

  assign blank_a = blank_pipe[ROM_LAT-1];
  assign obs_a   = obs_pipe[ROM_LAT-1];
  assign hit_a   = hit_pipe[ROM_LAT-1];

  genvar g;
  generate
    for (g = 0; g < NUM_SPRITES; g++) begin : g_sprite
      localparam logic [NUM_SPRITES-1:0] SELF = NUM_SPRITES'(1) << g;
      logic signed [CW-1:0] dx, dy;
      logic [ADDR_W-1:0]    col, row;

      assign dx = px - $signed({2'b00, sprite_x[g*COORD_W +: COORD_W]});
      assign dy = py - $signed({2'b00, sprite_y[g*COORD_W +: COORD_W]});
      assign hit[g] = sprite_en[g] && (dx >= SPR_LO) && (dx <= SPR_HI)
                                   && (dy >= SPR_LO) && (dy <= SPR_HI);
      assign col = ADDR_W'(dx - SPR_LO);
      assign row = ADDR_W'(dy - SPR_LO);
      assign rom_addr[g*ADDR_W +: ADDR_W] = hit[g] ? (col + row * ADDR_W'(SPRITE_DIM)) : '0;

      assign opaque[g]   = hit_a[g] && (rom_rgb[g*12 +: 12] != KEY_RGB);
      assign coll_set[g] = blank_a && opaque[g] && ((opaque & ~SELF) != '0);
      assign obs_set[g]  = blank_a && opaque[g] && obs_a;
    end
  endgenerate

  assign odx = px - $signed({2'b00, obs_xy[2*COORD_W-1 -: COORD_W]});
  assign ody = py - $signed({2'b00, obs_xy[COORD_W-1:0]});
  assign obs_hit = obs_en && (odx >= OBS_XLO) && (odx <= OBS_XHI)
                          && (ody >= OBS_YLO) && (ody <= OBS_YHI);

  // Raster-side qualifiers ride alongside the ROM/background latency.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        blank_pipe[i] <= 1'b0;
        obs_pipe[i]   <= 1'b0;
        hit_pipe[i]   <= '0;
      end
    end else begin
      blank_pipe[0] <= blank;
      obs_pipe[0]   <= obs_hit;
      hit_pipe[0]   <= hit;
      for (int i = 1; i < ROM_LAT; i++) begin
        blank_pipe[i] <= blank_pipe[i-1];
        obs_pipe[i]   <= obs_pipe[i-1];
        hit_pipe[i]   <= hit_pipe[i-1];
      end
    end
  end

  // Scanning from the highest index down lets the lowest-index opaque sprite win.
  always_comb begin
    pix = bg_rgb;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) pix = rom_rgb[i*12 +: 12];
    end
    if (!blank_a || obs_a) pix = 12'h000;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      red        <= 4'h0;
      green      <= 4'h0;
      blue       <= 4'h0;
      coll_acc   <= '0;
      obs_acc    <= '0;
      coll_frame <= '0;
      obs_frame  <= '0;
    end else begin
      {red, green, blue} <= pix;
      if (frame_start) begin
        coll_frame <= coll_acc;
        obs_frame  <= obs_acc;
        coll_acc   <= coll_set;
        obs_acc    <= obs_set;
      end else begin
        coll_acc   <= coll_acc | coll_set;
        obs_acc    <= obs_acc | obs_set;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - table, sequence and random checks for sprite_compositor
module tb_sprite_compositor;

  localparam int H = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start;
  logic [19:0] sprite_x, sprite_y;
  logic [1:0]  sprite_en;
  logic [19:0] obs_xy;
  logic        obs_en;
  logic [19:0] rom_addr;
  logic [23:0] rom_rgb;
  logic [11:0] bg_rgb;
  logic [3:0]  red, green, blue;
  logic [1:0]  coll_frame, obs_frame;

  always #5 clk = ~clk;

  sprite_compositor #(
    .NUM_SPRITES(2), .SPRITE_DIM(24), .COORD_W(10), .ADDR_W(10), .ROM_LAT(1),
    .KEY_RGB(12'hF0F), .OBS_HW(20), .OBS_HH(12)
  ) dut (
    .Clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_en(sprite_en), .obs_xy(obs_xy), .obs_en(obs_en), .rom_addr(rom_addr),
    .rom_rgb(rom_rgb), .bg_rgb(bg_rgb), .red(red), .green(green), .blue(blue),
    .coll_frame(coll_frame), .obs_frame(obs_frame)
  );

  typedef struct {
    logic [9:0]  x, y;
    logic        blank, fs;
    logic [9:0]  s0x, s0y, s1x, s1y;
    logic [1:0]  en;
    logic [9:0]  ox, oy;
    logic        oe;
    logic [11:0] r0, r1, bg;
  } pix_t;

  typedef struct {
    pix_t        p;
    int          a0, a1;
    logic [11:0] rgb;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] q[$];
  pix_t        prev;
  logic [1:0]  acc_c, acc_o, cf, of;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic pix_t mk(int x, int y, int bl, int s0x, int s0y, int s1x, int s1y, int en,
                              int ox, int oy, int oe, int r0, int r1, int bg);
    pix_t p;
    p.x = 10'(x);     p.y = 10'(y);     p.blank = bl[0]; p.fs = 1'b0;
    p.s0x = 10'(s0x); p.s0y = 10'(s0y); p.s1x = 10'(s1x); p.s1y = 10'(s1y);
    p.en = 2'(en);    p.ox = 10'(ox);   p.oy = 10'(oy);   p.oe = oe[0];
    p.r0 = 12'(r0);   p.r1 = 12'(r1);   p.bg = 12'(bg);
    return p;
  endfunction

  // Reference model: plain integer geometry straight from the pixel description.
  function automatic int off_x(pix_t p, int i);
    return int'(p.x) - (i == 0 ? int'(p.s0x) : int'(p.s1x));
  endfunction
  function automatic int off_y(pix_t p, int i);
    return int'(p.y) - (i == 0 ? int'(p.s0y) : int'(p.s1y));
  endfunction
  function automatic bit sp_hit(pix_t p, int i);
    int dx = off_x(p, i);
    int dy = off_y(p, i);
    return p.en[i] && dx >= -H && dx <= H - 1 && dy >= -H && dy <= H - 1;
  endfunction
  function automatic int sp_addr(pix_t p, int i);
    if (!sp_hit(p, i)) return 0;
    return ((off_x(p, i) + H) + (off_y(p, i) + H) * 24) % 1024;
  endfunction
  function automatic bit ob_hit(pix_t p);
    int dx = int'(p.x) - int'(p.ox);
    int dy = int'(p.y) - int'(p.oy);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return p.oe && dx <= 20 && dy <= 12;
  endfunction
  function automatic bit opq(pix_t p, int i);
    return sp_hit(p, i) && ((i == 0 ? p.r0 : p.r1) != 12'hF0F);
  endfunction
  function automatic logic [11:0] exp_rgb(pix_t p);
    if (!p.blank || ob_hit(p)) return 12'h000;
    if (opq(p, 0)) return p.r0;
    if (opq(p, 1)) return p.r1;
    return p.bg;
  endfunction
  function automatic logic [1:0] c_set(pix_t p);
    return (p.blank && opq(p, 0) && opq(p, 1)) ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [1:0] o_set(pix_t p);
    return (p.blank && ob_hit(p)) ? {opq(p, 1), opq(p, 0)} : 2'b00;
  endfunction

  task automatic drive(input pix_t p, input pix_t d);
    DrawX = p.x; DrawY = p.y; blank = p.blank; frame_start = p.fs;
    sprite_x = {p.s1x, p.s0x}; sprite_y = {p.s1y, p.s0y}; sprite_en = p.en;
    obs_xy = {p.ox, p.oy}; obs_en = p.oe;
    rom_rgb = {d.r1, d.r0}; bg_rgb = d.bg;
  endtask

  // One pixel per call: coordinates of p with ROM/background data of the previous pixel.
  task automatic step(input pix_t p, input bit tbl, input int ta0, input int ta1,
                      input logic [11:0] trgb, input string nm);
    logic [11:0] eo;
    @(negedge clk);
    eo = q.pop_front();
    chk({nm, " rgb(px-2)"}, 32'({red, green, blue}), 32'(eo));
    chk({nm, " coll_frame"}, 32'(coll_frame), 32'(cf));
    chk({nm, " obs_frame"}, 32'(obs_frame), 32'(of));
    if (p.fs) begin
      cf = acc_c; of = acc_o;
      acc_c = c_set(prev); acc_o = o_set(prev);
    end else begin
      acc_c = acc_c | c_set(prev); acc_o = acc_o | o_set(prev);
    end
    drive(p, prev);
    #1;
    chk({nm, " rom_addr0"}, 32'(rom_addr[9:0]), 32'(tbl ? ta0 : sp_addr(p, 0)));
    chk({nm, " rom_addr1"}, 32'(rom_addr[19:10]), 32'(tbl ? ta1 : sp_addr(p, 1)));
    q.push_back(tbl ? trgb : exp_rgb(p));
    prev = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pix_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    drive(z, z);
    q.delete();
    q.push_back(12'h000);
    q.push_back(12'h000);
    acc_c = '0; acc_o = '0; cf = '0; of = '0;
    prev = z;
  endtask

  function automatic pix_t rnd_pix();
    pix_t p;
    p.s0x = 10'($urandom_range(0, 1023));
    p.s0y = 10'($urandom_range(0, 1023));
    p.x   = p.s0x + 10'($urandom_range(0, 30)) - 10'd15;
    p.y   = p.s0y + 10'($urandom_range(0, 30)) - 10'd15;
    p.s1x = p.s0x + 10'($urandom_range(0, 20)) - 10'd10;
    p.s1y = p.s0y + 10'($urandom_range(0, 20)) - 10'd10;
    p.ox  = p.x + 10'($urandom_range(0, 50)) - 10'd25;
    p.oy  = p.y + 10'($urandom_range(0, 30)) - 10'd15;
    p.en  = 2'($urandom_range(0, 3));
    p.oe  = ($urandom_range(0, 2) == 0);
    p.blank = ($urandom_range(0, 7) != 0);
    p.fs  = ($urandom_range(0, 24) == 0);
    p.r0  = ($urandom_range(0, 2) == 0) ? 12'hF0F : 12'($urandom);
    p.r1  = ($urandom_range(0, 2) == 0) ? 12'hF0F : 12'($urandom);
    p.bg  = 12'($urandom);
    return p;
  endfunction

  initial begin
    vec_t tv[$];
    pix_t idle, idle_fs, hitp;

    tv.push_back('{mk(88, 88, 1, 100, 100, 500, 400, 1, 0, 0, 0, 'h0F0, 'h000, 'h123), 0, 0, 12'h0F0});
    tv.push_back('{mk(111, 111, 1, 100, 100, 500, 400, 1, 0, 0, 0, 'h0F0, 'h000, 'h123), 575, 0, 12'h0F0});
    tv.push_back('{mk(112, 111, 1, 100, 100, 500, 400, 1, 0, 0, 0, 'h0F0, 'h000, 'h123), 0, 0, 12'h123});
    tv.push_back('{mk(0, 0, 1, 5, 5, 500, 400, 1, 0, 0, 0, 'h0F0, 'h000, 'h123), 175, 0, 12'h0F0});
    tv.push_back('{mk(1023, 0, 1, 5, 5, 500, 400, 1, 0, 0, 0, 'h0F0, 'h000, 'h123), 0, 0, 12'h123});
    tv.push_back('{mk(300, 300, 1, 300, 300, 305, 300, 3, 0, 0, 0, 'hF0F, 'h00F, 'h123), 300, 295, 12'h00F});
    tv.push_back('{mk(300, 300, 1, 300, 300, 305, 300, 3, 0, 0, 0, 'hF00, 'h00F, 'h123), 300, 295, 12'hF00});
    tv.push_back('{mk(200, 200, 1, 500, 400, 200, 200, 2, 200, 200, 1, 'h0F0, 'h00F, 'h123), 0, 300, 12'h000});
    tv.push_back('{mk(220, 200, 1, 500, 400, 500, 400, 0, 200, 200, 1, 'h0F0, 'h00F, 'hABC), 0, 0, 12'h000});
    tv.push_back('{mk(221, 200, 1, 500, 400, 500, 400, 0, 200, 200, 1, 'h0F0, 'h00F, 'hABC), 0, 0, 12'hABC});
    tv.push_back('{mk(200, 212, 1, 500, 400, 500, 400, 0, 200, 200, 1, 'h0F0, 'h00F, 'hABC), 0, 0, 12'h000});
    tv.push_back('{mk(200, 213, 1, 500, 400, 500, 400, 0, 200, 200, 1, 'h0F0, 'h00F, 'hABC), 0, 0, 12'hABC});
    tv.push_back('{mk(180, 188, 1, 500, 400, 500, 400, 0, 200, 200, 1, 'h0F0, 'h00F, 'hABC), 0, 0, 12'h000});
    tv.push_back('{mk(300, 300, 0, 300, 300, 305, 300, 3, 0, 0, 0, 'hF00, 'h00F, 'h123), 300, 295, 12'h000});

    idle    = mk(0, 0, 1, 500, 400, 500, 400, 0, 0, 0, 0, 0, 0, 'h5A5);
    idle_fs = idle;
    idle_fs.fs = 1'b1;
    hitp    = mk(300, 300, 1, 300, 300, 305, 300, 3, 0, 0, 0, 'hF00, 'h00F, 'h123);

    reset_n = 1'b1;
    #2;
    do_reset();
    #1;
    chk("reset rgb", 32'({red, green, blue}), 32'h0);
    chk("reset coll_frame", 32'(coll_frame), 32'h0);
    chk("reset obs_frame", 32'(obs_frame), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (tv[i]) step(tv[i].p, 1'b1, tv[i].a0, tv[i].a1, tv[i].rgb, $sformatf("vec%0d", i));

    step(idle_fs, 1'b0, 0, 0, 12'h0, "snap");
    chk("snap coll_frame", 32'(coll_frame), 32'h3);
    chk("snap obs_frame", 32'(obs_frame), 32'h2);

    step(idle_fs, 1'b0, 0, 0, 12'h0, "clear");
    chk("clear coll_frame", 32'(coll_frame), 32'h0);
    step(hitp, 1'b0, 0, 0, 12'h0, "coin_hit");
    step(idle_fs, 1'b0, 0, 0, 12'h0, "coin_fs");
    chk("coincident coll_frame", 32'(coll_frame), 32'h0);
    step(idle, 1'b0, 0, 0, 12'h0, "coin_gap");
    step(idle_fs, 1'b0, 0, 0, 12'h0, "coin_next");
    chk("deferred coll_frame", 32'(coll_frame), 32'h3);

    step(hitp, 1'b0, 0, 0, 12'h0, "pre_rst0");
    step(hitp, 1'b0, 0, 0, 12'h0, "pre_rst1");
    #2;
    do_reset();
    #1;
    chk("midrst rgb", 32'({red, green, blue}), 32'h0);
    chk("midrst coll_frame", 32'(coll_frame), 32'h0);
    chk("midrst obs_frame", 32'(obs_frame), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 400; n++) step(rnd_pix(), 1'b0, 0, 0, 12'h0, $sformatf("rnd%0d", n));
    step(idle, 1'b0, 0, 0, 12'h0, "flush0");
    step(idle, 1'b0, 0, 0, 12'h0, "flush1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel compositor for the VGA game display. It overlays up to NUM_SPRITES 24×24 keyed sprites (snake heads, and any future entities) plus one solid obstacle box on a background pixel stream. It generates sprite ROM addresses from the raster position and aligns the ROM/background latency through a delay pipeline. It also accumulates per-frame, per-sprite collision flags that game logic reads once per frame. It sits between the VGA controller/ROM banks and the DAC outputs.

## Interface
- NUM_SPRITES, 2: number of sprite channels; index 0 has highest priority.
- SPRITE_DIM, 24: sprite edge length in pixels; must be even.
- COORD_W, 10: raster and position coordinate width.
- ADDR_W, 10: per-sprite ROM address width; requires SPRITE_DIM² ≤ 2^ADDR_W.
- ROM_LAT, 1: cycles from rom_addr/DrawX to valid rom_rgb/bg_rgb; must be ≥1.
- KEY_RGB, 12'hF0F: transparent colour key as {r,g,b}.
- OBS_HW, 20 / OBS_HH, 12: obstacle half-width and half-height.
- Clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX, DrawY  in  COORD_W each  current raster position.
- blank  in  1  1 = active video pixel.
- frame_start  in  1  one-cycle pulse at start of each frame.
- sprite_x, sprite_y  in  NUM_SPRITES*COORD_W each  sprite centre positions; sprite i occupies bits [i*COORD_W +: COORD_W].
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- obs_xy  in  2*COORD_W  obstacle centre as {x,y}.
- obs_en  in  1  obstacle enable.
- rom_addr  out  NUM_SPRITES*ADDR_W  combinational sprite ROM addresses.
- rom_rgb  in  NUM_SPRITES*12  sprite ROM/palette data, ROM_LAT cycles after address.
- bg_rgb  in  12  background pixel, ROM_LAT cycles after DrawX/DrawY.
- red, green, blue  out  4 each  registered output colour.
- coll_frame  out  NUM_SPRITES  collision flags for the previous frame.
- obs_frame  out  NUM_SPRITES  obstacle-hit flags for the previous frame.

## Operation
- Hit test: sprite i hits when sprite_en[i] and x−H ≤ DrawX ≤ x+H−1 and y−H ≤ DrawY ≤ y+H−1, with H=SPRITE_DIM/2.
  - Compute in COORD_W+2-bit signed arithmetic. Positions near 0 or the right edge must not wrap.
- Address: rom_addr_i = (DrawX−x+H) + (DrawY−y+H)*SPRITE_DIM when hit, else 0. Truncate to ADDR_W.
- Obstacle hit: obs_en and |DrawX−ox| ≤ OBS_HW and |DrawY−oy| ≤ OBS_HH, inclusive, same signed width.
- Delay line: blank, hit vector and obstacle hit are delayed ROM_LAT stages to align with rom_rgb and bg_rgb.
- A sprite is opaque at a pixel when its aligned hit bit is 1 and its rom_rgb ≠ KEY_RGB.
- Priority, first match wins:
  - aligned blank=0 → 0;
  - obstacle → 12'h000;
  - lowest-index opaque sprite → its rom_rgb;
  - otherwise bg_rgb.
- Collision accumulators (coll_acc, obs_acc): evaluated only on aligned active pixels.
  - coll_acc[i] sets when sprite i is opaque and any other sprite is opaque on the same pixel.
  - obs_acc[i] sets when sprite i is opaque and the obstacle hits.
  - Both are sticky within a frame.
- frame_start: coll_frame ← coll_acc and obs_frame ← obs_acc, then both accumulators clear.
  - If a set condition occurs in the same cycle as frame_start, it lands in the cleared accumulator (new frame), not in the snapshot.
- Reset: red/green/blue, coll_frame, obs_frame, accumulators and all delay stages go to 0, asynchronously. Output stays 0 until ROM_LAT+1 cycles after the first valid pixel following reset release.

## Timing
- rom_addr is combinational from DrawX, DrawY and the sprite positions, with zero latency.
- Pixel presented at cycle t appears on red/green/blue at cycle t+ROM_LAT+1.
- Throughput is one pixel per cycle, with no stalls.
- coll_frame and obs_frame update on the edge after frame_start is sampled. They hold stable for the whole next frame.
- Sprite positions may change at any cycle. Each pixel uses the positions present at its own cycle t.

## Test plan
- Sprite 0 at (100,100), DrawX=88, DrawY=88, ROM_LAT=1, rom_rgb=12'h0F0 → rom_addr_0=0, output 0/F/0 at t+2. DrawX=111, DrawY=111 → rom_addr_0=575. DrawX=112 → no hit, bg_rgb output.
- Sprite 0 at (5,5), DrawX=0, DrawY=0 → hit, rom_addr_0=7+7*24=175. DrawX=1023 → no hit (no wrap).
- Sprites 0 and 1 overlapping:
  - sprite 0 pixel = KEY_RGB, sprite 1 = 12'h00F → output 00F, no collision;
  - both opaque → sprite 0 colour, coll_acc=2'b11;
  - next frame_start → coll_frame=2'b11, accumulators 0.
- Obstacle at (200,200) over opaque sprite 1 → output 000, obs_frame[1]=1 after frame_start. Obstacle pixel at DrawX=220 hits, DrawX=221 misses.
- Collision coincident with frame_start → coll_frame=0; the following frame_start reports the flag.
- blank=0 pixels → output 0, no accumulator change. Assert reset_n low mid-frame → all outputs 0 immediately.
